// File: rtl/riscv_core_id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, load-use stall and
// MEM/WB operand forwarding applied combinationally at the stage outputs.
module riscv_core_id_ex_stage #(
   parameter int XLEN  = 64,
   parameter int RADDR = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_id_valid,
   output logic             o_id_ready,
   input  logic [XLEN-1:0]  i_id_rs1_data,
   input  logic [XLEN-1:0]  i_id_rs2_data,
   input  logic [XLEN-1:0]  i_id_imm,
   input  logic [XLEN-1:0]  i_id_pc,
   input  logic [RADDR-1:0] i_id_rs1_addr,
   input  logic [RADDR-1:0] i_id_rs2_addr,
   input  logic [RADDR-1:0] i_id_rd_addr,
   input  logic [3:0]       i_id_alu_control,
   input  logic             i_id_alu_isword,
   input  logic             i_id_srca_sel,
   input  logic             i_id_srcb_sel,
   input  logic             i_id_regwrite,
   input  logic             i_id_memread,
   input  logic             i_id_memwrite,
   input  logic             i_flush,
   input  logic             i_ex_ready,
   input  logic [RADDR-1:0] i_mem_rd_addr,
   input  logic             i_mem_regwrite,
   input  logic [XLEN-1:0]  i_mem_result,
   input  logic [RADDR-1:0] i_wb_rd_addr,
   input  logic             i_wb_regwrite,
   input  logic [XLEN-1:0]  i_wb_result,
   output logic             o_ex_valid,
   output logic [XLEN-1:0]  o_alu_srca,
   output logic [XLEN-1:0]  o_alu_srcb,
   output logic [3:0]       o_alu_control,
   output logic             o_alu_isword,
   output logic [XLEN-1:0]  o_ex_store_data,
   output logic [RADDR-1:0] o_ex_rd_addr,
   output logic             o_ex_regwrite,
   output logic             o_ex_memread,
   output logic             o_ex_memwrite
);

   logic             r_valid;
   logic [XLEN-1:0]  r_rs1_data;
   logic [XLEN-1:0]  r_rs2_data;
   logic [XLEN-1:0]  r_imm;
   logic [XLEN-1:0]  r_pc;
   logic [RADDR-1:0] r_rs1_addr;
   logic [RADDR-1:0] r_rs2_addr;
   logic [RADDR-1:0] r_rd_addr;
   logic [3:0]       r_alu_control;
   logic             r_alu_isword;
   logic             r_srca_sel;
   logic             r_srcb_sel;
   logic             r_regwrite;
   logic             r_memread;
   logic             r_memwrite;

   logic             w_hazard;
   logic             w_accept;
   logic [XLEN-1:0]  w_fwd_rs1;
   logic [XLEN-1:0]  w_fwd_rs2;

   // MEM result wins over WB; x0 always reads the held register value.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [RADDR-1:0] addr,
      input logic [XLEN-1:0]  held,
      input logic [RADDR-1:0] mem_rd,
      input logic             mem_we,
      input logic [XLEN-1:0]  mem_val,
      input logic [RADDR-1:0] wb_rd,
      input logic             wb_we,
      input logic [XLEN-1:0]  wb_val
   );
      logic [XLEN-1:0] res;
      if (addr == {RADDR{1'b0}}) begin
         res = held;
      end else if (mem_we && (mem_rd == addr)) begin
         res = mem_val;
      end else if (wb_we && (wb_rd == addr)) begin
         res = wb_val;
      end else begin
         res = held;
      end
      return res;
   endfunction

   assign w_hazard = r_valid & r_memread & (r_rd_addr != {RADDR{1'b0}}) &
                     ((r_rd_addr == i_id_rs1_addr) | (r_rd_addr == i_id_rs2_addr));
   assign o_id_ready = (~r_valid | i_ex_ready) & ~w_hazard & ~i_flush;
   assign w_accept   = i_id_valid & o_id_ready;

   // Pipeline register: flush > capture > drain (bubble) > hold.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid       <= 1'b0;
         r_rs1_data    <= {XLEN{1'b0}};
         r_rs2_data    <= {XLEN{1'b0}};
         r_imm         <= {XLEN{1'b0}};
         r_pc          <= {XLEN{1'b0}};
         r_rs1_addr    <= {RADDR{1'b0}};
         r_rs2_addr    <= {RADDR{1'b0}};
         r_rd_addr     <= {RADDR{1'b0}};
         r_alu_control <= 4'b0000;
         r_alu_isword  <= 1'b0;
         r_srca_sel    <= 1'b0;
         r_srcb_sel    <= 1'b0;
         r_regwrite    <= 1'b0;
         r_memread     <= 1'b0;
         r_memwrite    <= 1'b0;
      end else if (i_flush) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
      end else if (w_accept) begin
         r_valid       <= 1'b1;
         r_rs1_data    <= i_id_rs1_data;
         r_rs2_data    <= i_id_rs2_data;
         r_imm         <= i_id_imm;
         r_pc          <= i_id_pc;
         r_rs1_addr    <= i_id_rs1_addr;
         r_rs2_addr    <= i_id_rs2_addr;
         r_rd_addr     <= i_id_rd_addr;
         r_alu_control <= i_id_alu_control;
         r_alu_isword  <= i_id_alu_isword;
         r_srca_sel    <= i_id_srca_sel;
         r_srcb_sel    <= i_id_srcb_sel;
         r_regwrite    <= i_id_regwrite;
         r_memread     <= i_id_memread;
         r_memwrite    <= i_id_memwrite;
      end else if (r_valid && i_ex_ready) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
      end
   end

   // Forwarding follows the live MEM/WB buses, even while the stage holds.
   always_comb begin
      w_fwd_rs1 = fwd_sel(r_rs1_addr, r_rs1_data, i_mem_rd_addr, i_mem_regwrite,
                          i_mem_result, i_wb_rd_addr, i_wb_regwrite, i_wb_result);
      w_fwd_rs2 = fwd_sel(r_rs2_addr, r_rs2_data, i_mem_rd_addr, i_mem_regwrite,
                          i_mem_result, i_wb_rd_addr, i_wb_regwrite, i_wb_result);
   end

   assign o_ex_valid      = r_valid;
   assign o_alu_srca      = r_srca_sel ? r_pc  : w_fwd_rs1;
   assign o_alu_srcb      = r_srcb_sel ? r_imm : w_fwd_rs2;
   assign o_ex_store_data = w_fwd_rs2;
   assign o_alu_control   = r_alu_control;
   assign o_alu_isword    = r_alu_isword;
   assign o_ex_rd_addr    = r_rd_addr;
   assign o_ex_regwrite   = r_regwrite;
   assign o_ex_memread    = r_memread;
   assign o_ex_memwrite   = r_memwrite;

endmodule

// File: tb/tb_riscv_core_id_ex_stage.sv
// Self-checking bench for riscv_core_id_ex_stage: directed scenarios followed by
// randomized traffic compared against a transaction-level model of the stage.
module tb_riscv_core_id_ex_stage;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_id_valid;
   logic        o_id_ready;
   logic [63:0] i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_pc;
   logic [4:0]  i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
   logic [3:0]  i_id_alu_control;
   logic        i_id_alu_isword, i_id_srca_sel, i_id_srcb_sel;
   logic        i_id_regwrite, i_id_memread, i_id_memwrite;
   logic        i_flush, i_ex_ready;
   logic [4:0]  i_mem_rd_addr, i_wb_rd_addr;
   logic        i_mem_regwrite, i_wb_regwrite;
   logic [63:0] i_mem_result, i_wb_result;
   logic        o_ex_valid;
   logic [63:0] o_alu_srca, o_alu_srcb, o_ex_store_data;
   logic [3:0]  o_alu_control;
   logic        o_alu_isword;
   logic [4:0]  o_ex_rd_addr;
   logic        o_ex_regwrite, o_ex_memread, o_ex_memwrite;

   int total = 0;
   int bad   = 0;

   riscv_core_id_ex_stage #(.XLEN(64), .RADDR(5)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
      .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
      .i_id_imm(i_id_imm), .i_id_pc(i_id_pc),
      .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
      .i_id_rd_addr(i_id_rd_addr), .i_id_alu_control(i_id_alu_control),
      .i_id_alu_isword(i_id_alu_isword), .i_id_srca_sel(i_id_srca_sel),
      .i_id_srcb_sel(i_id_srcb_sel), .i_id_regwrite(i_id_regwrite),
      .i_id_memread(i_id_memread), .i_id_memwrite(i_id_memwrite),
      .i_flush(i_flush), .i_ex_ready(i_ex_ready),
      .i_mem_rd_addr(i_mem_rd_addr), .i_mem_regwrite(i_mem_regwrite),
      .i_mem_result(i_mem_result), .i_wb_rd_addr(i_wb_rd_addr),
      .i_wb_regwrite(i_wb_regwrite), .i_wb_result(i_wb_result),
      .o_ex_valid(o_ex_valid), .o_alu_srca(o_alu_srca), .o_alu_srcb(o_alu_srcb),
      .o_alu_control(o_alu_control), .o_alu_isword(o_alu_isword),
      .o_ex_store_data(o_ex_store_data), .o_ex_rd_addr(o_ex_rd_addr),
      .o_ex_regwrite(o_ex_regwrite), .o_ex_memread(o_ex_memread),
      .o_ex_memwrite(o_ex_memwrite)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: the instruction currently held by the stage.
   typedef struct packed {
      logic        valid;
      logic [63:0] rs1_data, rs2_data, imm, pc;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  ctl;
      logic        isword, asel, bsel, rw, mr, mw;
   } instr_t;

   instr_t m;

   function automatic instr_t incoming();
      instr_t t;
      t.valid = 1'b1;
      t.rs1_data = i_id_rs1_data; t.rs2_data = i_id_rs2_data;
      t.imm = i_id_imm; t.pc = i_id_pc;
      t.rs1 = i_id_rs1_addr; t.rs2 = i_id_rs2_addr; t.rd = i_id_rd_addr;
      t.ctl = i_id_alu_control; t.isword = i_id_alu_isword;
      t.asel = i_id_srca_sel; t.bsel = i_id_srcb_sel;
      t.rw = i_id_regwrite; t.mr = i_id_memread; t.mw = i_id_memwrite;
      return t;
   endfunction

   function automatic logic load_use();
      return m.valid && m.mr && (m.rd != 5'd0) &&
             (m.rd == i_id_rs1_addr || m.rd == i_id_rs2_addr);
   endfunction

   function automatic logic exp_ready();
      if (i_flush || load_use()) return 1'b0;
      return !m.valid || i_ex_ready;
   endfunction

   function automatic logic [63:0] operand(input logic [4:0] a, input logic [63:0] d);
      if (a == 5'd0) return d;
      if (i_mem_regwrite && i_mem_rd_addr == a) return i_mem_result;
      if (i_wb_regwrite && i_wb_rd_addr == a) return i_wb_result;
      return d;
   endfunction

   function automatic logic [206:0] exp_vec();
      logic [63:0] a, b;
      a = m.asel ? m.pc  : operand(m.rs1, m.rs1_data);
      b = m.bsel ? m.imm : operand(m.rs2, m.rs2_data);
      return {exp_ready(), m.valid, a, b, operand(m.rs2, m.rs2_data), m.rd, m.ctl,
              m.isword, m.rw, m.mr, m.mw};
   endfunction

   wire [206:0] dut_vec = {o_id_ready, o_ex_valid, o_alu_srca, o_alu_srcb, o_ex_store_data,
                           o_ex_rd_addr, o_alu_control, o_alu_isword, o_ex_regwrite,
                           o_ex_memread, o_ex_memwrite};

   task automatic tick();
      logic   rdy;
      instr_t nxt;
      @(posedge i_clk);
      rdy = exp_ready();
      nxt = m;
      if (!i_rst_n) begin
         nxt = '0;
      end else if (i_flush) begin
         nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0;
      end else if (i_id_valid && rdy) begin
         nxt = incoming();
      end else if (m.valid && i_ex_ready) begin
         nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0;
      end
      m = nxt;
      #1;
   endtask

   task automatic clear_inputs();
      i_id_valid = 1'b0;
      i_id_rs1_data = 64'd0; i_id_rs2_data = 64'd0; i_id_imm = 64'd0; i_id_pc = 64'd0;
      i_id_rs1_addr = 5'd0; i_id_rs2_addr = 5'd0; i_id_rd_addr = 5'd0;
      i_id_alu_control = 4'd0; i_id_alu_isword = 1'b0;
      i_id_srca_sel = 1'b0; i_id_srcb_sel = 1'b0;
      i_id_regwrite = 1'b0; i_id_memread = 1'b0; i_id_memwrite = 1'b0;
      i_flush = 1'b0; i_ex_ready = 1'b1;
      i_mem_rd_addr = 5'd0; i_mem_regwrite = 1'b0; i_mem_result = 64'd0;
      i_wb_rd_addr = 5'd0; i_wb_regwrite = 1'b0; i_wb_result = 64'd0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      clear_inputs();
      m = '0;
      #3;
      total++; if (o_ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_ex_valid); end
      total++; if (o_alu_srca !== 64'd0 || o_alu_srcb !== 64'd0) begin bad++; $display("FAIL reset_src: got %h/%h want 0/0", o_alu_srca, o_alu_srcb); end
      total++; if ({o_ex_regwrite, o_ex_memread, o_ex_memwrite} !== 3'b000) begin bad++; $display("FAIL reset_ctl: got %b want 000", {o_ex_regwrite, o_ex_memread, o_ex_memwrite}); end
      tick(); tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_add();
      clear_inputs();
      i_id_valid = 1'b1; i_id_rs1_addr = 5'd1; i_id_rs2_addr = 5'd2; i_id_rd_addr = 5'd5;
      i_id_rs1_data = 64'd5; i_id_rs2_data = 64'd7; i_id_regwrite = 1'b1;
      tick();
      i_id_valid = 1'b0;
      #1;
      total++; if (o_ex_valid !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", o_ex_valid); end
      total++; if (o_alu_srca !== 64'd5) begin bad++; $display("FAIL add_srca: got %h want 5", o_alu_srca); end
      total++; if (o_alu_srcb !== 64'd7) begin bad++; $display("FAIL add_srcb: got %h want 7", o_alu_srcb); end
      total++; if (o_id_ready !== 1'b1) begin bad++; $display("FAIL add_ready: got %b want 1", o_id_ready); end
      total++; if (o_ex_rd_addr !== 5'd5 || o_ex_regwrite !== 1'b1) begin bad++; $display("FAIL add_rd: got %0d/%b want 5/1", o_ex_rd_addr, o_ex_regwrite); end
      tick();
   endtask

   task automatic test_forward();
      clear_inputs();
      i_id_valid = 1'b1; i_id_rs1_addr = 5'd3; i_id_rs2_addr = 5'd3; i_id_rs1_data = 64'd1;
      i_id_rs2_data = 64'd2; i_id_srcb_sel = 1'b1; i_id_imm = 64'h77;
      tick();
      i_id_valid = 1'b0; i_ex_ready = 1'b0;
      i_mem_regwrite = 1'b1; i_mem_rd_addr = 5'd3; i_mem_result = 64'h55;
      i_wb_regwrite = 1'b1; i_wb_rd_addr = 5'd3; i_wb_result = 64'h66;
      #1;
      total++; if (o_alu_srca !== 64'h55) begin bad++; $display("FAIL fwd_mem: got %h want 55", o_alu_srca); end
      total++; if (o_alu_srcb !== 64'h77 || o_ex_store_data !== 64'h55) begin bad++; $display("FAIL fwd_store: got %h/%h want 77/55", o_alu_srcb, o_ex_store_data); end
      i_mem_regwrite = 1'b0;
      #1;
      total++; if (o_alu_srca !== 64'h66) begin bad++; $display("FAIL fwd_wb: got %h want 66", o_alu_srca); end
      i_wb_regwrite = 1'b0;
      #1;
      total++; if (o_alu_srca !== 64'd1) begin bad++; $display("FAIL fwd_none: got %h want 1", o_alu_srca); end
      i_ex_ready = 1'b1;
      tick();
   endtask

   task automatic test_x0();
      clear_inputs();
      i_id_valid = 1'b1; i_id_rs1_addr = 5'd0; i_id_rs1_data = 64'h11;
      tick();
      i_id_valid = 1'b0; i_ex_ready = 1'b0;
      i_mem_regwrite = 1'b1; i_mem_rd_addr = 5'd0; i_mem_result = 64'hFF;
      i_wb_regwrite = 1'b1; i_wb_rd_addr = 5'd0; i_wb_result = 64'hEE;
      #1;
      total++; if (o_alu_srca !== 64'h11) begin bad++; $display("FAIL x0_guard: got %h want 11", o_alu_srca); end
      i_ex_ready = 1'b1;
      tick();
   endtask

   task automatic test_load_use();
      clear_inputs();
      i_id_valid = 1'b1; i_id_rs1_addr = 5'd1; i_id_rd_addr = 5'd4;
      i_id_memread = 1'b1; i_id_regwrite = 1'b1;
      tick();
      clear_inputs();
      i_id_valid = 1'b1; i_id_rs1_addr = 5'd5; i_id_rs2_addr = 5'd4; i_id_rd_addr = 5'd6;
      i_id_rs2_data = 64'h9; i_id_regwrite = 1'b1;
      #1;
      total++; if (o_id_ready !== 1'b0) begin bad++; $display("FAIL lu_stall: got %b want 0", o_id_ready); end
      tick();
      total++; if (o_ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble: got %b want 0", o_ex_valid); end
      total++; if ({o_ex_regwrite, o_ex_memread, o_ex_memwrite} !== 3'b000) begin bad++; $display("FAIL lu_bubble_ctl: got %b want 000", {o_ex_regwrite, o_ex_memread, o_ex_memwrite}); end
      total++; if (o_id_ready !== 1'b1) begin bad++; $display("FAIL lu_release: got %b want 1", o_id_ready); end
      i_wb_regwrite = 1'b1; i_wb_rd_addr = 5'd4; i_wb_result = 64'h1234;
      tick();
      i_id_valid = 1'b0;
      #1;
      total++; if (o_ex_valid !== 1'b1 || o_ex_rd_addr !== 5'd6) begin bad++; $display("FAIL lu_accept: got %b/%0d want 1/6", o_ex_valid, o_ex_rd_addr); end
      total++; if (o_alu_srcb !== 64'h1234 || o_ex_store_data !== 64'h1234) begin bad++; $display("FAIL lu_wbfwd: got %h/%h want 1234/1234", o_alu_srcb, o_ex_store_data); end
      tick();
   endtask

   task automatic test_stall();
      clear_inputs();
      i_id_valid = 1'b1; i_id_rs1_addr = 5'd1; i_id_rs1_data = 64'hA1;
      tick();
      i_ex_ready = 1'b0; i_id_rs1_data = 64'hB2; i_id_rs1_addr = 5'd2;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (o_id_ready !== 1'b0) begin bad++; $display("FAIL stall_ready c%0d: got %b want 0", c, o_id_ready); end
         total++; if (o_alu_srca !== 64'hA1 || o_ex_valid !== 1'b1) begin bad++; $display("FAIL stall_hold c%0d: got %h/%b want a1/1", c, o_alu_srca, o_ex_valid); end
         tick();
      end
      i_ex_ready = 1'b1;
      #1;
      total++; if (o_id_ready !== 1'b1) begin bad++; $display("FAIL stall_resume: got %b want 1", o_id_ready); end
      tick();
      i_id_valid = 1'b0;
      #1;
      total++; if (o_alu_srca !== 64'hB2 || o_ex_valid !== 1'b1) begin bad++; $display("FAIL stall_capture: got %h/%b want b2/1", o_alu_srca, o_ex_valid); end
   endtask

   task automatic test_flush();
      i_ex_ready = 1'b0;
      i_flush = 1'b1; i_id_valid = 1'b1; i_id_rs1_data = 64'hC3;
      i_id_regwrite = 1'b1; i_id_memwrite = 1'b1;
      #1;
      total++; if (o_id_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", o_id_ready); end
      tick();
      total++; if (o_ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", o_ex_valid); end
      total++; if (o_ex_regwrite !== 1'b0 || o_ex_memwrite !== 1'b0) begin bad++; $display("FAIL flush_ctl: got %b%b want 00", o_ex_regwrite, o_ex_memwrite); end
      i_flush = 1'b0; i_id_valid = 1'b0;
      tick();
      total++; if (o_ex_valid !== 1'b0 || o_alu_srca === 64'hC3) begin bad++; $display("FAIL flush_discard: got %b/%h want 0/not c3", o_ex_valid, o_alu_srca); end
   endtask

   task automatic test_async_reset();
      clear_inputs();
      i_id_valid = 1'b1; i_id_rs1_addr = 5'd2; i_id_rs1_data = 64'hDEAD; i_id_memwrite = 1'b1;
      tick();
      i_id_valid = 1'b0;
      #2;
      i_rst_n = 1'b0;
      m = '0;
      #1;
      total++; if (o_ex_valid !== 1'b0 || o_ex_memwrite !== 1'b0) begin bad++; $display("FAIL arst_ctl: got %b/%b want 0/0", o_ex_valid, o_ex_memwrite); end
      total++; if (o_alu_srca !== 64'd0) begin bad++; $display("FAIL arst_data: got %h want 0", o_alu_srca); end
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         i_id_valid = 1'($urandom_range(0, 3) != 0);
         i_id_rs1_data = {$urandom, $urandom}; i_id_rs2_data = {$urandom, $urandom};
         i_id_imm = {$urandom, $urandom}; i_id_pc = {$urandom, $urandom};
         i_id_rs1_addr = 5'($urandom_range(0, 5)); i_id_rs2_addr = 5'($urandom_range(0, 5));
         i_id_rd_addr = 5'($urandom_range(0, 5));
         i_id_alu_control = 4'($urandom); i_id_alu_isword = 1'($urandom);
         i_id_srca_sel = 1'($urandom); i_id_srcb_sel = 1'($urandom);
         i_id_regwrite = 1'($urandom); i_id_memread = 1'($urandom); i_id_memwrite = 1'($urandom);
         i_flush = 1'($urandom_range(0, 11) == 0);
         i_ex_ready = 1'($urandom_range(0, 3) != 0);
         i_mem_rd_addr = 5'($urandom_range(0, 5)); i_mem_regwrite = 1'($urandom);
         i_mem_result = {$urandom, $urandom};
         i_wb_rd_addr = 5'($urandom_range(0, 5)); i_wb_regwrite = 1'($urandom);
         i_wb_result = {$urandom, $urandom};
         #1;
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL random n%0d: got %h want %h", n, dut_vec, exp_vec());
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_forward();
      test_x0();
      test_load_use();
      test_stall();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_core_id_ex_stage.md
Name: riscv_core_id_ex_stage

Overview:
- ID/EX pipeline stage that registers decoded operands and controls and drives the ALU operand and control inputs.
- Resolves data hazards at its output: operand forwarding from MEM/WB and load-use stall/bubble insertion.
- Uses a valid/ready handshake with decode (upstream) and execute (downstream).

Parameters:
- XLEN, 64, datapath width.
- RADDR, 5, register address width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  decode presents an instruction
- o_id_ready  out  1  stage accepts the decode instruction this cycle
- i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_pc  in  XLEN each  decoded operands
- i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr  in  RADDR each  register indices
- i_id_alu_control  in  4  ALU opcode
- i_id_alu_isword  in  1  32-bit W-op
- i_id_srca_sel  in  1  0: rs1, 1: pc
- i_id_srcb_sel  in  1  0: rs2, 1: imm
- i_id_regwrite, i_id_memread, i_id_memwrite  in  1 each  controls
- i_flush  in  1  kill the held instruction (branch/trap)
- i_ex_ready  in  1  execute accepts the held instruction
- i_mem_rd_addr  in  RADDR  MEM-stage destination register
- i_mem_regwrite  in  1  MEM-stage write enable
- i_mem_result  in  XLEN  MEM-stage forwarding value
- i_wb_rd_addr  in  RADDR  WB-stage destination register
- i_wb_regwrite  in  1  WB-stage write enable
- i_wb_result  in  XLEN  WB-stage forwarding value
- o_ex_valid  out  1  held instruction valid
- o_alu_srca, o_alu_srcb  out  XLEN each  to ALU
- o_alu_control  out  4  to ALU
- o_alu_isword  out  1  to ALU
- o_ex_store_data  out  XLEN  forwarded rs2 value
- o_ex_rd_addr  out  RADDR  destination register
- o_ex_regwrite, o_ex_memread, o_ex_memwrite  out  1 each  qualified controls

Behaviour:
- Reset (i_rst_n=0, asynchronous): all registers cleared to 0. Outputs o_ex_valid=0, all controls 0, all data 0, and o_alu_srca/srcb=0.
- Load-use hazard (combinational), all terms ANDed:
  - o_ex_valid=1 and o_ex_memread=1.
  - o_ex_rd_addr!=0.
  - ex_rd equals i_id_rs1_addr, or equals i_id_rs2_addr.
- o_id_ready = (!o_ex_valid | i_ex_ready) & !hazard & !i_flush.
- Register update priority per rising edge:
  1. i_flush=1: o_ex_valid<=0; regwrite/memread/memwrite<=0. Any accept is discarded.
  2. i_id_valid & o_id_ready: capture all id_* fields; o_ex_valid<=1.
  3. o_ex_valid & i_ex_ready (no capture): o_ex_valid<=0 and controls cleared. A bubble is inserted, e.g. on a load-use hazard.
  4. Otherwise: hold all state (downstream stall).
- Latency: an instruction accepted at edge N appears at outputs after edge N. Throughput is one per cycle when i_ex_ready=1 and there is no hazard.
- Controls are qualified by the registered valid. Registered controls are zero whenever o_ex_valid=0.
- Forwarding is combinational every cycle on the live MEM/WB inputs, including during hold.
  - fwd_rs1: use i_mem_result if i_mem_regwrite & i_mem_rd_addr==ex_rs1 & ex_rs1!=0.
  - Else use i_wb_result if i_wb_regwrite & i_wb_rd_addr==ex_rs1 & ex_rs1!=0.
  - Else use the registered rs1_data. fwd_rs2 is formed the same way.
  - MEM has priority over WB. Register x0 is never forwarded.
- Operand selection:
  - o_alu_srca = srca_sel ? pc : fwd_rs1.
  - o_alu_srcb = srcb_sel ? imm : fwd_rs2.
  - o_ex_store_data = fwd_rs2 always.
- o_alu_control and o_alu_isword come directly from registers.
- Load-use sequence: stall for exactly one cycle; a bubble enters EX. The dependent instruction is accepted the next cycle and picks up the load data via the WB forward.
- A flush during a hazard or downstream stall still clears the stage. o_id_ready=0 while i_flush=1.
- Reset asserted mid-operation clears state immediately, regardless of clock.

Test Plan:
- Reset, then ADD: rs1_data=5, rs2_data=7, control=0000, valid=1. After one edge: o_ex_valid=1, srca=5, srcb=7, o_id_ready=1.
- MEM forward: EX holds rs1=3 (data 1); mem_regwrite=1, mem_rd=3, mem_result=0x55; wb_rd=3, wb_result=0x66. Required: srca=0x55. With mem_regwrite=0, srca=0x66.
- x0 guard: ex_rs1=0, mem_rd=0, mem_regwrite=1, mem_result=0xFF. Required: srca=registered rs1_data=0.
- Load-use: EX holds LD rd=4 (memread=1); ID presents rs2=4. Required: o_id_ready=0 for 1 cycle, next o_ex_valid=0 with controls 0. Then the instruction is accepted, and WB forward 0x1234 appears on srcb.
- Downstream stall: i_ex_ready=0 for 3 cycles with i_id_valid=1. Required: o_id_ready=0 and outputs held. When i_ex_ready rises, the new instruction is captured at the next edge.
- Flush: i_flush=1 concurrent with i_id_valid=1. Required: next o_ex_valid=0, o_ex_regwrite=0, o_ex_memwrite=0, and the instruction is discarded.
